// File: rtl/sumsq_feed_pkg.sv
// Shared types and constants for the sum-of-squares feeder and the square-root unit it drives.
package sumsq_feed_pkg;

    localparam int unsigned SUM_W    = 32;
    localparam int unsigned IN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SQX,
        SQY,
        ISSUE
    } state_t;

endpackage

// File: rtl/sumsq_feed_if.sv
// Vector-in / operand-out handshake bundle between the requester, sumsq_feed and the square-root unit.
interface sumsq_feed_if
    import sumsq_feed_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
) ();

    logic                   start_i;
    logic signed [IN_W-1:0] x_i;
    logic signed [IN_W-1:0] y_i;
    logic                   busy_o;
    logic [SUM_W-1:0]       sum_o;
    logic                   sqrt_start_o;
    logic [SUM_W-1:0]       sqrt_a_o;
    logic                   sqrt_busy_i;

    modport slave (
        input  start_i, x_i, y_i, sqrt_busy_i,
        output busy_o, sum_o, sqrt_start_o, sqrt_a_o
    );

    modport master (
        output start_i, x_i, y_i, sqrt_busy_i,
        input  busy_o, sum_o, sqrt_start_o, sqrt_a_o
    );

endinterface

// File: rtl/sumsq_mac_step.sv
// One step of a shift-add multiplier: adds mcand << cnt into acc when the multiplier bit is set.
module sumsq_mac_step
    import sumsq_feed_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned CNT_W = 4
) (
    input  logic [SUM_W-1:0] i_acc,
    input  logic [IN_W-1:0]  i_mcand,
    input  logic             i_bit,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [SUM_W-1:0] o_acc
);

    logic [SUM_W-1:0] w_part;

    assign w_part = SUM_W'(i_mcand) << i_cnt;
    assign o_acc  = i_bit ? (i_acc + w_part) : i_acc;

endmodule

// File: rtl/sumsq_feed.sv
// Computes x^2 + y^2 with a bit-serial shift-add multiplier and issues the sum to the square-root unit.
module sumsq_feed
    import sumsq_feed_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    sumsq_feed_if.slave bus
);

    localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [SUM_W-1:0] r_acc, w_acc_nx;
    logic [IN_W-1:0]  r_magx, w_magx_nx;
    logic [IN_W-1:0]  r_magy, w_magy_nx;
    logic [SUM_W-1:0] r_sum, w_sum_nx;
    logic             r_busy;

    logic [IN_W-1:0]  w_xabs, w_yabs;
    logic [IN_W-1:0]  w_mcand;
    logic             w_mbit;
    logic [SUM_W-1:0] w_acc_step;

    // Two's-complement magnitude; the most negative value maps to 2^(IN_W-1) exactly.
    assign w_xabs = bus.x_i[IN_W-1] ? IN_W'(~bus.x_i + IN_W'(1)) : IN_W'(bus.x_i);
    assign w_yabs = bus.y_i[IN_W-1] ? IN_W'(~bus.y_i + IN_W'(1)) : IN_W'(bus.y_i);

    assign w_mcand = (r_state == SQY) ? r_magy : r_magx;
    assign w_mbit  = w_mcand[r_cnt];

    sumsq_mac_step #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) u_mac_step (
        .i_acc   (r_acc),
        .i_mcand (w_mcand),
        .i_bit   (w_mbit),
        .i_cnt   (r_cnt),
        .o_acc   (w_acc_step)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_acc_nx   = r_acc;
        w_magx_nx  = r_magx;
        w_magy_nx  = r_magy;
        w_sum_nx   = r_sum;
        case (r_state)
            IDLE: begin
                if (bus.start_i && !r_busy) begin
                    w_magx_nx  = w_xabs;
                    w_magy_nx  = w_yabs;
                    w_acc_nx   = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = SQX;
                end
            end
            SQX: begin
                w_acc_nx = w_acc_step;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = SQY;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            SQY: begin
                w_acc_nx = w_acc_step;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = '0;
                    w_sum_nx   = w_acc_step;
                    w_state_nx = ISSUE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ISSUE: begin
                if (!bus.sqrt_busy_i) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_magx  <= '0;
            r_magy  <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_acc   <= w_acc_nx;
            r_magx  <= w_magx_nx;
            r_magy  <= w_magy_nx;
            r_sum   <= w_sum_nx;
            r_busy  <= (w_state_nx != IDLE);
        end
    end

    assign bus.busy_o       = r_busy;
    assign bus.sum_o        = r_sum;
    assign bus.sqrt_a_o     = r_sum;
    assign bus.sqrt_start_o = (r_state == ISSUE) && !bus.sqrt_busy_i;

endmodule

// File: tb/tb_sumsq_feed.sv
// Directed bench for sumsq_feed: latency, arithmetic corners, back-pressure, ignored starts and reset.
module tb_sumsq_feed;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    sumsq_feed_if #(.IN_W(16)) bus ();

    sumsq_feed #(.IN_W(16)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv(input int n);
        while (cyc < n) tick();
    endtask

    task automatic set_sb(input logic v);
        bus.sqrt_busy_i = v;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Accept edge is cycle 0; returns sampling in cycle 1 with the inputs scrambled.
    task automatic accept(input logic signed [15:0] x, input logic signed [15:0] y);
        bus.start_i = 1'b1;
        bus.x_i     = x;
        bus.y_i     = y;
        tick();
        cyc         = 1;
        bus.start_i = 1'b0;
        bus.x_i     = 16'($urandom);
        bus.y_i     = 16'($urandom);
    endtask

    task automatic vec(input string tag, input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic [31:0] exp);
        accept(x, y);
        chk({tag, "_busy_c1"}, 32'(bus.busy_o), 32'd1);
        adv(32);
        chk({tag, "_start_c32"}, 32'(bus.sqrt_start_o), 32'd0);
        adv(33);
        chk({tag, "_start_c33"}, 32'(bus.sqrt_start_o), 32'd1);
        chk({tag, "_sum_c33"}, bus.sum_o, exp);
        chk({tag, "_a_c33"}, bus.sqrt_a_o, exp);
        adv(34);
        chk({tag, "_busy_c34"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_start_c34"}, 32'(bus.sqrt_start_o), 32'd0);
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        cyc             = 0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.x_i         = '0;
        bus.y_i         = '0;
        bus.sqrt_busy_i = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_sum", bus.sum_o, 32'd0);
        chk("rst_a", bus.sqrt_a_o, 32'd0);
        chk("rst_start", 32'(bus.sqrt_start_o), 32'd0);
        rst = 1'b0;
        tick();

        vec("v3_4", 16'sd3, 16'sd4, 32'd25);
        vec("vmin_min", -16'sd32768, -16'sd32768, 32'h8000_0000);
        vec("vm1_1", -16'sd1, 16'sd1, 32'd2);
        vec("v0_0", 16'sd0, 16'sd0, 32'd0);
        vec("v32767_m5", 16'sd32767, -16'sd5, 32'd1073676314);

        // Square-root unit busy over cycles 30..45.
        accept(16'sd6, 16'sd8);
        adv(30);
        set_sb(1'b1);
        adv(33);
        chk("bp_start_c33", 32'(bus.sqrt_start_o), 32'd0);
        chk("bp_sum_c33", bus.sum_o, 32'd100);
        adv(45);
        chk("bp_start_c45", 32'(bus.sqrt_start_o), 32'd0);
        chk("bp_busy_c45", 32'(bus.busy_o), 32'd1);
        adv(46);
        set_sb(1'b0);
        chk("bp_start_c46", 32'(bus.sqrt_start_o), 32'd1);
        chk("bp_busy_c46", 32'(bus.busy_o), 32'd1);
        chk("bp_a_c46", bus.sqrt_a_o, 32'd100);
        adv(47);
        chk("bp_busy_c47", 32'(bus.busy_o), 32'd0);
        chk("bp_start_c47", 32'(bus.sqrt_start_o), 32'd0);

        // Start pulse mid-run must be dropped, not queued.
        accept(16'sd7, 16'sd24);
        adv(10);
        bus.start_i = 1'b1;
        bus.x_i     = 16'sd1;
        bus.y_i     = 16'sd1;
        tick();
        bus.start_i = 1'b0;
        adv(33);
        chk("ign_start_c33", 32'(bus.sqrt_start_o), 32'd1);
        chk("ign_sum_c33", bus.sum_o, 32'd625);
        adv(34);
        chk("ign_busy_c34", 32'(bus.busy_o), 32'd0);
        adv(36);
        chk("ign_busy_c36", 32'(bus.busy_o), 32'd0);
        chk("ign_sum_c36", bus.sum_o, 32'd625);

        // Reset mid-SQY.
        accept(16'sd100, 16'sd100);
        adv(20);
        rst = 1'b1;
        #1;
        chk("rmid_busy", 32'(bus.busy_o), 32'd0);
        chk("rmid_sum", bus.sum_o, 32'd0);
        chk("rmid_a", bus.sqrt_a_o, 32'd0);
        chk("rmid_start", 32'(bus.sqrt_start_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        vec("v5_12", 16'sd5, 16'sd12, 32'd169);

        // Reset in ISSUE while the square-root unit frees up: no start may escape.
        accept(16'sd8, 16'sd15);
        adv(30);
        set_sb(1'b1);
        adv(35);
        chk("riss_sum_pre", bus.sum_o, 32'd289);
        rst             = 1'b1;
        bus.sqrt_busy_i = 1'b0;
        #1;
        chk("riss_start", 32'(bus.sqrt_start_o), 32'd0);
        chk("riss_sum", bus.sum_o, 32'd0);
        chk("riss_busy", 32'(bus.busy_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("riss_idle_start", 32'(bus.sqrt_start_o), 32'd0);
        vec("v9_40", -16'sd9, 16'sd40, 32'd1681);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
